// File: rtl/stack_pkg.sv
// ============================================================================
// Module   : stack_pkg
// Brief    : Shared defaults and entry types for the coordinate LIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stack_pkg;

    localparam int unsigned c_WIDTH = 4;
    localparam int unsigned c_DEPTH = 16;

    typedef logic [c_WIDTH-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } entry_t;

    function automatic entry_t make_entry(input coord_t x, input coord_t y);
        entry_t e;
        e.x = x;
        e.y = y;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
// ============================================================================
// Module   : stack_mem
// Brief    : DEPTH-entry register array, one write port, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_mem
    import stack_pkg::*;
#(
    parameter type         ENTRY_T = entry_t,
    parameter int unsigned DEPTH   = c_DEPTH,
    parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  ENTRY_T            wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output ENTRY_T            rdata
);

    ENTRY_T r_mem [DEPTH];
    ENTRY_T r_rdata;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // A read and write to the same address in one cycle returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/stack.sv
// ============================================================================
// Module   : stack
// Brief    : Synchronous LIFO of (x, y) coordinate pairs with overflow/underflow
//            flag. Define STACK_STATUS_EN to expose empty/full/count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = c_WIDTH,
    parameter int unsigned DEPTH = c_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           xIn,
    input  logic [WIDTH-1:0]           yIn,
    output logic [WIDTH-1:0]           xOut,
    output logic [WIDTH-1:0]           yOut,
    output logic                       fail
`ifdef STACK_STATUS_EN
    ,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
`endif
);

    localparam int unsigned c_PTR_W  = $clog2(DEPTH) + 1;
    localparam int unsigned c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_DEPTH_CNT = c_PTR_W'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } slot_t;

    logic [c_PTR_W-1:0]  r_count;
    logic                r_fail;

    logic [c_PTR_W-1:0]  w_count_nxt;
    logic                w_fail_nxt;
    logic                w_empty;
    logic                w_full;
    logic                w_we;
    logic                w_re;
    logic [c_ADDR_W-1:0] w_waddr;
    logic [c_ADDR_W-1:0] w_top_addr;
    slot_t               w_wdata;
    slot_t               w_rdata;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_top_addr = c_ADDR_W'(r_count - c_ONE);
    assign w_wdata    = '{x: xIn, y: yIn};

    always_comb begin
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_waddr     = r_count[c_ADDR_W-1:0];
        w_count_nxt = r_count;
        w_fail_nxt  = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!w_full) begin
                    w_we        = 1'b1;
                    w_count_nxt = r_count + c_ONE;
                end else begin
                    w_fail_nxt  = 1'b1;
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    w_re        = 1'b1;
                    w_count_nxt = r_count - c_ONE;
                end else begin
                    w_fail_nxt  = 1'b1;
                end
            end
            2'b11: begin
                // Swap the top in place; on an empty stack only the push lands.
                w_we = 1'b1;
                if (!w_empty) begin
                    w_re    = 1'b1;
                    w_waddr = w_top_addr;
                end else begin
                    w_count_nxt = c_ONE;
                    w_fail_nxt  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_fail  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    stack_mem #(
        .ENTRY_T (slot_t),
        .DEPTH   (DEPTH),
        .ADDR_W  (c_ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we & ~rst),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .re    (w_re),
        .raddr (w_top_addr),
        .rdata (w_rdata)
    );

    assign xOut = w_rdata.x;
    assign yOut = w_rdata.y;
    assign fail = r_fail;

`ifdef STACK_STATUS_EN
    assign empty = w_empty;
    assign full  = w_full;
    assign count = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack.sv
// ============================================================================
// Module   : tb_stack
// Brief    : Directed scoreboard bench for the coordinate LIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack;

    localparam int unsigned c_WIDTH = 4;
    localparam int unsigned c_DEPTH = 16;

    typedef struct {
        logic [c_WIDTH-1:0] x;
        logic [c_WIDTH-1:0] y;
        logic               fail;
    } exp_t;

    typedef struct {
        logic [c_WIDTH-1:0] x;
        logic [c_WIDTH-1:0] y;
    } pair_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               push;
    logic               pop;
    logic [c_WIDTH-1:0] xIn;
    logic [c_WIDTH-1:0] yIn;
    logic [c_WIDTH-1:0] xOut;
    logic [c_WIDTH-1:0] yOut;
    logic               fail;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t  exp_q[$];
    pair_t mdl[$];
    logic [c_WIDTH-1:0] m_x = '0;
    logic [c_WIDTH-1:0] m_y = '0;

    always #5 clk = ~clk;

    stack #(
        .WIDTH (c_WIDTH),
        .DEPTH (c_DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .xIn  (xIn),
        .yIn  (yIn),
        .xOut (xOut),
        .yOut (yOut),
        .fail (fail)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle, predict its outcome into the scoreboard, then compare.
    task automatic step(input logic r, input logic pu, input logic po,
                        input logic [c_WIDTH-1:0] x, input logic [c_WIDTH-1:0] y,
                        input string tag);
        exp_t  e;
        pair_t p;
        rst = r; push = pu; pop = po; xIn = x; yIn = y;
        p.x = x; p.y = y;
        e.fail = 1'b0;
        if (r) begin
            mdl.delete();
            m_x = '0; m_y = '0;
        end else if (pu && po) begin
            if (mdl.size() > 0) begin
                m_x = mdl[$].x; m_y = mdl[$].y;
                mdl[mdl.size()-1] = p;
            end else begin
                mdl.push_back(p);
                e.fail = 1'b1;
            end
        end else if (pu) begin
            if (mdl.size() < c_DEPTH) mdl.push_back(p);
            else e.fail = 1'b1;
        end else if (po) begin
            if (mdl.size() > 0) begin
                p = mdl.pop_back();
                m_x = p.x; m_y = p.y;
            end else begin
                e.fail = 1'b1;
            end
        end
        e.x = m_x; e.y = m_y;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".x"},    8'(xOut), 8'(e.x));
        check({tag, ".y"},    8'(yOut), 8'(e.y));
        check({tag, ".fail"}, 8'(fail), 8'(e.fail));
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; xIn = '0; yIn = '0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, "reset");
        check("reset_x_const", 8'(xOut), 8'h0);

        // Single push/pop then hold
        step(0, 1, 0, 1, 0, "push10");
        step(0, 0, 1, 0, 0, "pop10");
        check("pop10_x_const", 8'(xOut), 8'h1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, "idle");
        check("idle_hold_x", 8'(xOut), 8'h1);

        // LIFO ordering and underflow
        step(0, 1, 0, 1, 2, "push12");
        step(0, 1, 0, 3, 4, "push34");
        step(0, 1, 0, 5, 6, "push56");
        step(0, 0, 1, 0, 0, "pop56");
        check("pop56_const", {xOut, yOut}, 8'h56);
        step(0, 0, 1, 0, 0, "pop34");
        step(0, 0, 1, 0, 0, "pop12");
        step(0, 0, 1, 0, 0, "underflow");
        check("underflow_fail_const", 8'(fail), 8'h1);
        check("underflow_hold_const", {xOut, yOut}, 8'h12);
        step(0, 0, 0, 0, 0, "fail_one_cycle");

        // Fill, overflow, pop top
        for (int i = 0; i < c_DEPTH; i++) step(0, 1, 0, 4'(i), ~4'(i), "fill");
        step(0, 1, 0, 4'hF, 4'hF, "overflow");
        check("overflow_fail_const", 8'(fail), 8'h1);
        step(0, 0, 1, 0, 0, "pop_after_full");
        check("pop_after_full_const", {xOut, yOut}, 8'hF0);
        for (int i = 0; i < c_DEPTH - 1; i++) step(0, 0, 1, 0, 0, "drain");
        step(0, 0, 1, 0, 0, "drain_underflow");

        // Swap with two entries, including a full-stack swap
        step(0, 1, 0, 1, 1, "swap_pre1");
        step(0, 1, 0, 4'hA, 4'hB, "swap_preAB");
        step(0, 1, 1, 7, 7, "swap77");
        check("swap_out_const", {xOut, yOut}, 8'hAB);
        step(0, 0, 1, 0, 0, "pop77");
        check("pop77_const", {xOut, yOut}, 8'h77);
        step(0, 0, 1, 0, 0, "pop11");
        for (int i = 0; i < c_DEPTH; i++) step(0, 1, 0, 4'(i + 3), 4'(i), "fill2");
        step(0, 1, 1, 4'hC, 4'hD, "swap_full");
        step(0, 1, 0, 4'h9, 4'h9, "overflow2");
        step(0, 0, 1, 0, 0, "pop_CD");
        check("pop_CD_const", {xOut, yOut}, 8'hCD);
        step(1, 0, 0, 0, 0, "reset2");

        // Push+pop on empty
        step(0, 1, 1, 2, 3, "swap_empty");
        check("swap_empty_fail_const", 8'(fail), 8'h1);
        step(0, 0, 1, 0, 0, "pop23");
        check("pop23_const", {xOut, yOut}, 8'h23);

        // Reset mid-sequence with push asserted
        step(0, 1, 0, 4, 4, "pre_rst1");
        step(0, 1, 0, 5, 5, "pre_rst2");
        step(0, 1, 0, 6, 6, "pre_rst3");
        step(0, 0, 1, 0, 0, "pre_rst_pop");
        step(1, 1, 0, 8, 8, "rst_with_push");
        check("rst_out_const", {xOut, yOut, 7'(fail)}, 15'h0);
        step(0, 0, 1, 0, 0, "pop_after_rst");
        check("pop_after_rst_const", 8'(fail), 8'h1);

        // Random traffic against the model
        for (int i = 0; i < 200; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom), 4'($urandom), "random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
